// File: rtl/lift_ctrl.sv
// lift_ctrl: single-car directional-collective dispatch controller for a
// 6-floor lift. Consumes latched hall/car calls and floor sensors, drives
// the motor and door. All outputs come straight from flops.
module lift_ctrl #(
    parameter int DOOR_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Hall_call_Up,
    input  logic [5:1] Hall_call_Down,
    input  logic [5:0] Car_call,
    input  logic [5:0] Sensor,
    output logic       OpenDoor,
    output logic       MotorUp,
    output logic       MotorDown,
    output logic [2:0] Floor,
    output logic       Dir
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN,
        DOOR_CLOSE
    } state_t;

    state_t           state_q, state_d;
    logic             open_door_q, open_door_d;
    logic             motor_up_q, motor_up_d;
    logic             motor_down_q, motor_down_d;
    logic [2:0]       floor_q, floor_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             relevel_q, relevel_d;

    // Calls widened to 6 bits so every floor indexes the same way; the
    // missing up-call at the top and down-call at the bottom read as 0.
    logic [5:0] hall_up_w;
    logic [5:0] hall_dn_w;
    logic [5:0] req;
    logic       sens_valid;
    logic [2:0] sens_idx;
    logic       above;
    logic       below;
    logic       car_here;
    logic       up_here;
    logic       dn_here;
    logic       req_here;
    logic       stop_up;
    logic       stop_dn;

    assign hall_up_w = {1'b0, Hall_call_Up};
    assign hall_dn_w = {Hall_call_Down, 1'b0};
    assign req       = Car_call | hall_up_w | hall_dn_w;

    // A sensor reading counts only when exactly one bit is set.
    assign sens_valid = (Sensor != 6'd0) && ((Sensor & (Sensor - 6'd1)) == 6'd0);

    assign car_here = |(Car_call & Sensor);
    assign up_here  = |(hall_up_w & Sensor);
    assign dn_here  = |(hall_dn_w & Sensor);
    assign req_here = car_here | up_here | dn_here;

    // Decode the sensed floor index and the requests ahead of / behind it.
    always_comb begin
        sens_idx = 3'd0;
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (Sensor[i]) begin
                sens_idx = 3'(i);
            end
        end
        for (int g = 0; g < 6; g++) begin
            if (3'(g) > sens_idx) begin
                above = above | req[g];
            end
            if (3'(g) < sens_idx) begin
                below = below | req[g];
            end
        end
    end

    // Passing a floor against the hall-call direction only stops when that
    // call is the last request in the travel direction.
    assign stop_up = car_here | up_here | (dn_here & ~above);
    assign stop_dn = car_here | dn_here | (up_here & ~below);

    // Next-state, direction, door counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        floor_d   = floor_q;
        cnt_d     = cnt_q;
        relevel_d = relevel_q;

        if (sens_valid) begin
            floor_d = sens_idx;
        end

        case (state_q)
            IDLE: begin
                relevel_d = 1'b0;
                if (sens_valid) begin
                    if (req_here) begin
                        state_d = DOOR_OPEN;
                        cnt_d   = '0;
                    end else if (dir_q && above) begin
                        state_d = MOVE_UP;
                    end else if (below) begin
                        state_d = MOVE_DOWN;
                        dir_d   = 1'b0;
                    end else if (above) begin
                        state_d = MOVE_UP;
                        dir_d   = 1'b1;
                    end
                end else if (|req) begin
                    // Lost position: creep down until any floor is sensed.
                    state_d   = MOVE_DOWN;
                    relevel_d = 1'b1;
                end
            end
            MOVE_UP: begin
                if (sens_valid) begin
                    if (stop_up) begin
                        state_d = DOOR_OPEN;
                        cnt_d   = '0;
                    end else if (Sensor[5]) begin
                        state_d = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (sens_valid) begin
                    if (relevel_q) begin
                        state_d   = IDLE;
                        relevel_d = 1'b0;
                    end else if (stop_dn) begin
                        state_d = DOOR_OPEN;
                        cnt_d   = '0;
                    end else if (Sensor[0]) begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DOOR_CLOSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOOR_CLOSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                relevel_d = 1'b0;
            end
        endcase

        open_door_d  = (state_d == DOOR_OPEN);
        motor_up_d   = (state_d == MOVE_UP);
        motor_down_d = (state_d == MOVE_DOWN);
    end

    // Single state register; reset drops motor and door immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            open_door_q  <= 1'b0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            floor_q      <= 3'd0;
            dir_q        <= 1'b1;
            cnt_q        <= '0;
            relevel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            open_door_q  <= open_door_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            relevel_q    <= relevel_d;
        end
    end

    assign OpenDoor  = open_door_q;
    assign MotorUp   = motor_up_q;
    assign MotorDown = motor_down_q;
    assign Floor     = floor_q;
    assign Dir       = dir_q;

endmodule

// File: tb/tb_lift_ctrl.sv
// tb_lift_ctrl: directed scenarios for lift_ctrl with hand-computed
// expectations; the bench plays the call-register stage and the shaft sensors.
module tb_lift_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Hall_call_Up;
    logic [5:1] Hall_call_Down;
    logic [5:0] Car_call;
    logic [5:0] Sensor;
    logic       OpenDoor;
    logic       MotorUp;
    logic       MotorDown;
    logic [2:0] Floor;
    logic       Dir;

    int checks;
    int failures;

    lift_ctrl #(.DOOR_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .Hall_call_Up  (Hall_call_Up),
        .Hall_call_Down(Hall_call_Down),
        .Car_call      (Car_call),
        .Sensor        (Sensor),
        .OpenDoor      (OpenDoor),
        .MotorUp       (MotorUp),
        .MotorDown     (MotorDown),
        .Floor         (Floor),
        .Dir           (Dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Remaining door cycle after the stop edge: 7 more open cycles,
    // one closed DOOR_CLOSE cycle, then IDLE with motors off.
    task automatic door_rest(input string tag);
        for (int i = 1; i < 8; i++) begin
            step();
            chk({tag, "_open"}, OpenDoor, 1'b1);
        end
        step();
        chk({tag, "_close"}, OpenDoor, 1'b0);
        step();
        chk({tag, "_idle_up"}, MotorUp, 1'b0);
        chk({tag, "_idle_dn"}, MotorDown, 1'b0);
        chk({tag, "_idle_door"}, OpenDoor, 1'b0);
    endtask

    // Safety invariants sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(MotorUp && MotorDown)) else begin
                failures++;
                $error("FAIL inv_both_motors observed=%b%b expected=not both", MotorUp, MotorDown);
            end
            checks++;
            assert (!(OpenDoor && (MotorUp || MotorDown))) else begin
                failures++;
                $error("FAIL inv_door_motor observed=%b%b%b expected=door not with motor",
                       OpenDoor, MotorUp, MotorDown);
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        Hall_call_Up   = '0;
        Hall_call_Down = '0;
        Car_call       = '0;
        Sensor         = '0;

        // Reset values.
        step();
        chk("rst_open", OpenDoor, 1'b0);
        chk("rst_up", MotorUp, 1'b0);
        chk("rst_dn", MotorDown, 1'b0);
        chk("rst_floor", Floor, 3'd0);
        chk("rst_dir", Dir, 1'b1);
        reset = 1'b0;

        // Floor 0 IDLE with a call at floor 0: door opens with no motor pulse.
        Sensor   = 6'b000001;
        Car_call = 6'b000001;
        step();
        chk("f0_open", OpenDoor, 1'b1);
        chk("f0_up", MotorUp, 1'b0);
        chk("f0_dn", MotorDown, 1'b0);
        Car_call = '0;
        door_rest("f0");

        // Floor 0 -> 2 on a car call, with a multi-hot reading in between.
        Car_call = 6'b000100;
        step();
        chk("t1_depart_up", MotorUp, 1'b1);
        chk("t1_dir", Dir, 1'b1);
        Sensor = 6'b000000;
        step();
        chk("t1_between_up", MotorUp, 1'b1);
        Sensor = 6'b000010;
        step();
        chk("t1_floor1", Floor, 3'd1);
        chk("t1_pass1_up", MotorUp, 1'b1);
        Sensor = 6'b000110;
        step();
        chk("t1_multi_floor", Floor, 3'd1);
        chk("t1_multi_up", MotorUp, 1'b1);
        chk("t1_multi_door", OpenDoor, 1'b0);
        step();
        chk("t1_multi2_up", MotorUp, 1'b1);
        Sensor = 6'b000100;
        step();
        chk("t1_stop_up", MotorUp, 1'b0);
        chk("t1_stop_open", OpenDoor, 1'b1);
        chk("t1_stop_floor", Floor, 3'd2);
        Car_call = '0;

        // Up-call at the open floor during the door cycle: no reopen, stays parked.
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t3_open", OpenDoor, 1'b1);
            if (i == 2) Hall_call_Up = 5'b00100;
            if (i == 3) Hall_call_Up = 5'b00000;
        end
        step();
        chk("t3_close", OpenDoor, 1'b0);
        step();
        step();
        step();
        chk("t3_park_open", OpenDoor, 1'b0);
        chk("t3_park_up", MotorUp, 1'b0);
        chk("t3_park_dn", MotorDown, 1'b0);

        // Floor 1 going up: pass down-call at 3, stop at 5, then serve 3 going down.
        reset = 1'b1;
        #1;
        Sensor            = 6'b000010;
        Hall_call_Down[3] = 1'b1;
        Car_call          = 6'b100000;
        reset             = 1'b0;
        step();
        chk("t2_depart_up", MotorUp, 1'b1);
        chk("t2_floor1", Floor, 3'd1);
        chk("t2_dir_up", Dir, 1'b1);
        Sensor = 6'b000000;
        step();
        Sensor = 6'b000100;
        step();
        Sensor = 6'b001000;
        step();
        chk("t2_pass3_up", MotorUp, 1'b1);
        chk("t2_pass3_door", OpenDoor, 1'b0);
        chk("t2_pass3_floor", Floor, 3'd3);
        Sensor = 6'b010000;
        step();
        Sensor = 6'b100000;
        step();
        chk("t2_stop5_open", OpenDoor, 1'b1);
        chk("t2_stop5_up", MotorUp, 1'b0);
        chk("t2_stop5_floor", Floor, 3'd5);
        Car_call = '0;
        door_rest("t2_f5");
        step();
        chk("t2_depart_dn", MotorDown, 1'b1);
        chk("t2_dir_dn", Dir, 1'b0);
        Sensor = 6'b010000;
        step();
        chk("t2_pass4_dn", MotorDown, 1'b1);
        chk("t2_pass4_floor", Floor, 3'd4);
        Sensor = 6'b001000;
        step();
        chk("t2_stop3_open", OpenDoor, 1'b1);
        chk("t2_stop3_dn", MotorDown, 1'b0);
        chk("t2_stop3_floor", Floor, 3'd3);
        chk("t2_stop3_dir", Dir, 1'b0);
        Hall_call_Down = '0;
        door_rest("t2_f3");

        // Reset mid-descent, then re-level and go up to floor 4.
        Car_call = 6'b000001;
        step();
        chk("t5_depart_dn", MotorDown, 1'b1);
        Sensor = 6'b000000;
        step();
        chk("t5_between_dn", MotorDown, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_async_dn", MotorDown, 1'b0);
        chk("t5_async_open", OpenDoor, 1'b0);
        chk("t5_async_floor", Floor, 3'd0);
        chk("t5_async_dir", Dir, 1'b1);
        Car_call = 6'b010000;
        reset    = 1'b0;
        step();
        chk("t5_relevel_dn", MotorDown, 1'b1);
        chk("t5_relevel_up", MotorUp, 1'b0);
        step();
        chk("t5_relevel2_dn", MotorDown, 1'b1);
        Sensor = 6'b000100;
        step();
        chk("t5_level_dn", MotorDown, 1'b0);
        chk("t5_level_open", OpenDoor, 1'b0);
        chk("t5_level_floor", Floor, 3'd2);
        step();
        chk("t5_depart_up", MotorUp, 1'b1);
        Sensor = 6'b001000;
        step();
        chk("t5_pass3_up", MotorUp, 1'b1);
        chk("t5_pass3_floor", Floor, 3'd3);
        Sensor = 6'b010000;
        step();
        chk("t5_stop4_open", OpenDoor, 1'b1);
        chk("t5_stop4_floor", Floor, 3'd4);
        Car_call = '0;
        door_rest("t5_f4");

        // Multi-hot near the top, then hard limit at floor 5 with no request left.
        Car_call = 6'b100000;
        step();
        chk("t6_depart_up", MotorUp, 1'b1);
        Sensor = 6'b110000;
        step();
        chk("t6_multi_floor", Floor, 3'd4);
        chk("t6_multi_up", MotorUp, 1'b1);
        chk("t6_multi_door", OpenDoor, 1'b0);
        Car_call = '0;
        Sensor   = 6'b100000;
        step();
        chk("t6_limit_up", MotorUp, 1'b0);
        chk("t6_limit_door", OpenDoor, 1'b0);
        chk("t6_limit_floor", Floor, 3'd5);
        step();
        chk("t6_park_up", MotorUp, 1'b0);
        chk("t6_park_dn", MotorDown, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
